// File: rtl/led_ring_decoder.sv
`default_nettype none
// ============================================================================
// led_ring_decoder : tracks a 5-position LED walker, reports steps/wraps/errors
// Optional: DWELL_MEAS_EN enables dwell-time measurement.   Revision: 1.0
// ============================================================================
module led_ring_decoder #(
  parameter int STABLE_CYC = 2,
  parameter int DWELL_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         led,
  output logic [2:0]         pos,
  output logic               locked,
  output logic               fault,
  output logic               step_pulse,
  output logic               dir,
  output logic               dir_valid,
  output logic               wrap_pulse,
  output logic               err_pulse,
  output logic [7:0]         err_cnt,
  output logic [DWELL_W-1:0] dwell_out
);

  localparam int SW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
  localparam logic [SW:0] STAB_ONE = (SW+1)'(1);
  localparam logic [SW:0] STAB_TGT = (SW+1)'(STABLE_CYC);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    LOCK  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    led_s;
  logic [2:0]    idx;
  logic          legal;
  logic [3:0]    delta;
  logic [SW:0]   stab_inc;
  logic [SW-1:0] stab_cnt, stab_cnt_nx;
  logic [2:0]    stab_idx, stab_idx_nx;
  logic [2:0]    pos_nx;
  logic          dir_nx, dir_valid_nx;
  logic          step_nx, wrap_nx, err_nx;
  logic [7:0]    err_cnt_nx, err_cnt_inc;
  logic          ev_step, ev_clear;

  always_comb begin
    idx   = 3'd0;
    legal = 1'b1;
    case (led_s)
      4'b0000: idx = 3'd0;
      4'b0001: idx = 3'd1;
      4'b0010: idx = 3'd2;
      4'b0100: idx = 3'd3;
      4'b1000: idx = 3'd4;
      default: legal = 1'b0;
    endcase
  end

  // Ring distance from the tracked position to the new one, in 0..4.
  always_comb begin
    delta = {1'b0, idx} + 4'd5 - {1'b0, pos};
    if (delta >= 4'd5) delta = delta - 4'd5;
  end

  assign stab_inc    = (stab_cnt != '0 && idx == stab_idx) ? ({1'b0, stab_cnt} + STAB_ONE) : STAB_ONE;
  assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_comb begin
    state_nx     = state;
    pos_nx       = pos;
    dir_nx       = dir;
    dir_valid_nx = dir_valid;
    step_nx      = 1'b0;
    wrap_nx      = 1'b0;
    err_nx       = 1'b0;
    err_cnt_nx   = err_cnt;
    stab_cnt_nx  = stab_cnt;
    stab_idx_nx  = stab_idx;
    ev_step      = 1'b0;
    ev_clear     = 1'b0;
    case (state)
      ACQ, FAULT: begin
        if (!legal) begin
          stab_cnt_nx = '0;
        end else if (stab_inc >= STAB_TGT) begin
          state_nx     = LOCK;
          pos_nx       = idx;
          dir_valid_nx = 1'b0;
          stab_cnt_nx  = '0;
          ev_clear     = 1'b1;
        end else begin
          stab_cnt_nx = stab_inc[SW-1:0];
          stab_idx_nx = idx;
        end
      end
      LOCK: begin
        if (!legal) begin
          state_nx     = FAULT;
          err_nx       = 1'b1;
          err_cnt_nx   = err_cnt_inc;
          dir_valid_nx = 1'b0;
          stab_cnt_nx  = '0;
          ev_clear     = 1'b1;
        end else if (idx != pos) begin
          pos_nx = idx;
          if (delta == 4'd1 || delta == 4'd4) begin
            step_nx      = 1'b1;
            dir_nx       = (delta == 4'd1);
            dir_valid_nx = 1'b1;
            wrap_nx      = (delta == 4'd1) ? (pos == 3'd4) : (pos == 3'd0);
            ev_step      = 1'b1;
          end else begin
            err_nx       = 1'b1;
            err_cnt_nx   = err_cnt_inc;
            dir_valid_nx = 1'b0;
            ev_clear     = 1'b1;
          end
        end
      end
      default: state_nx = ACQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQ;
      led_s      <= 4'b0000;
      pos        <= 3'd0;
      dir        <= 1'b0;
      dir_valid  <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= 8'd0;
      stab_cnt   <= '0;
      stab_idx   <= 3'd0;
    end else begin
      state      <= state_nx;
      led_s      <= led;
      pos        <= pos_nx;
      dir        <= dir_nx;
      dir_valid  <= dir_valid_nx;
      step_pulse <= step_nx;
      wrap_pulse <= wrap_nx;
      err_pulse  <= err_nx;
      err_cnt    <= err_cnt_nx;
      stab_cnt   <= stab_cnt_nx;
      stab_idx   <= stab_idx_nx;
    end
  end

  assign locked = (state == LOCK);
  assign fault  = (state == FAULT);

`ifdef DWELL_MEAS_EN
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
  logic [DWELL_W-1:0] dwell_cnt;

  // Counter restarts at 1 on a step so dwell_out equals cycles the old position was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt <= '0;
      dwell_out <= '0;
    end else if (ev_step) begin
      dwell_out <= dwell_cnt;
      dwell_cnt <= DWELL_W'(1);
    end else if (ev_clear) begin
      dwell_cnt <= '0;
    end else if (state == LOCK && dwell_cnt != DWELL_MAX) begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end
`else
  logic unused_dwell;
  assign unused_dwell = ev_step ^ ev_clear;
  assign dwell_out    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_ring_decoder.sv
`default_nettype none
// Testbench for led_ring_decoder: directed scenarios plus random walk against a rule model.
module tb_led_ring_decoder;

  localparam int STABLE_CYC = 2;
  localparam int DWELL_W    = 16;
`ifdef DWELL_MEAS_EN
  localparam bit DW_EN = 1'b1;
`else
  localparam bit DW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [3:0] led;
  logic [2:0] pos;
  logic locked, fault, step_pulse, dir, dir_valid, wrap_pulse, err_pulse;
  logic [7:0] err_cnt;
  logic [DWELL_W-1:0] dwell_out;

  led_ring_decoder #(.STABLE_CYC(STABLE_CYC), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .led(led), .pos(pos), .locked(locked), .fault(fault),
    .step_pulse(step_pulse), .dir(dir), .dir_valid(dir_valid), .wrap_pulse(wrap_pulse),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .dwell_out(dwell_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int steps_seen, wraps_seen, errs_seen;

  // Reference model: mode 0 = acquiring, 1 = tracking, 2 = faulted
  int m_mode, m_pos, m_dir, m_dv, m_step, m_wrap, m_err, m_errcnt;
  int m_run, m_run_pos, m_dw, m_dwout;
  logic [3:0] m_ls;
  logic [3:0] pats [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  function automatic int decode(input logic [3:0] v);
    for (int i = 0; i < 5; i++) if (pats[i] == v) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_dir = 0; m_dv = 0; m_step = 0; m_wrap = 0; m_err = 0;
    m_errcnt = 0; m_run = 0; m_run_pos = 0; m_dw = 0; m_dwout = 0; m_ls = 4'b0000;
  endtask

  task automatic model_clock();
    int p, d;
    p = decode(m_ls);
    m_step = 0; m_wrap = 0; m_err = 0;
    if (m_mode != 1) begin
      if (p < 0) m_run = 0;
      else begin
        m_run = (m_run > 0 && p == m_run_pos) ? m_run + 1 : 1;
        m_run_pos = p;
        if (m_run >= STABLE_CYC) begin
          m_mode = 1; m_pos = p; m_dv = 0; m_run = 0; m_dw = 0;
        end
      end
    end else if (p < 0) begin
      m_err = 1; m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
      m_mode = 2; m_dv = 0; m_dw = 0; m_run = 0;
    end else if (p != m_pos) begin
      d = (p - m_pos + 5) % 5;
      if (d == 1 || d == 4) begin
        m_step = 1; m_dir = (d == 1); m_dv = 1;
        m_wrap = (d == 1 && m_pos == 4) || (d == 4 && m_pos == 0);
        if (DW_EN) begin m_dwout = m_dw; m_dw = 1; end
      end else begin
        m_err = 1; m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
        m_dv = 0; m_dw = 0;
      end
      m_pos = p;
    end else if (DW_EN && m_dw < (1 << DWELL_W) - 1) begin
      m_dw = m_dw + 1;
    end
    m_ls = led;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pos", 32'(pos), 32'(m_pos));
    chk("locked", 32'(locked), 32'(m_mode == 1));
    chk("fault", 32'(fault), 32'(m_mode == 2));
    chk("step_pulse", 32'(step_pulse), 32'(m_step));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("dir_valid", 32'(dir_valid), 32'(m_dv));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    chk("err_pulse", 32'(err_pulse), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
    chk("dwell_out", 32'(dwell_out), 32'(m_dwout));
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic tick(input logic [3:0] v);
    led = v;
    @(posedge clk);
    model_clock();
    #1;
    chk_all();
    if (step_pulse === 1'b1) steps_seen++;
    if (wrap_pulse === 1'b1) wraps_seen++;
    if (err_pulse === 1'b1) errs_seen++;
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  initial begin
    int rp, r, n;
    logic [3:0] v;
    rst = 1'b0;
    led = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all();

    // 1: lock on 0000
    rst = 1'b1;
    hold(4'b0000, 2);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_pos", 32'(pos), 32'd0);
    chk("t1_dir_valid", 32'(dir_valid), 32'd0);

    // 2: forward lap, each position held 10 cycles
    steps_seen = 0; wraps_seen = 0;
    hold(4'b0001, 10); hold(4'b0010, 10); hold(4'b0100, 10);
    hold(4'b1000, 10); hold(4'b0000, 10);
    chk("t2_steps", 32'(steps_seen), 32'd5);
    chk("t2_wraps", 32'(wraps_seen), 32'd1);
    chk("t2_dir", 32'(dir), 32'd1);
    chk("t2_dwell", 32'(dwell_out), DW_EN ? 32'd10 : 32'd0);

    // 3: backward wrap 0 -> 4 with two-cycle latency
    tick(4'b1000);
    chk("t3_no_early_step", 32'(step_pulse), 32'd0);
    tick(4'b1000);
    chk("t3_step", 32'(step_pulse), 32'd1);
    chk("t3_dir", 32'(dir), 32'd0);
    chk("t3_wrap", 32'(wrap_pulse), 32'd1);
    chk("t3_pos", 32'(pos), 32'd4);

    // 4: illegal pattern, single error, then re-acquire at 0100
    errs_seen = 0;
    hold(4'b0011, 2);
    chk("t4_err", 32'(err_pulse), 32'd1);
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_locked", 32'(locked), 32'd0);
    hold(4'b0011, 3);
    chk("t4_one_err", 32'(errs_seen), 32'd1);
    hold(4'b0100, 4);
    chk("t4_relock", 32'(locked), 32'd1);
    chk("t4_pos", 32'(pos), 32'd3);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);

    // 5: skip 1 -> 3
    hold(4'b0010, 3); hold(4'b0001, 3);
    hold(4'b0100, 2);
    chk("t5_err", 32'(err_pulse), 32'd1);
    chk("t5_err_cnt", 32'(err_cnt), 32'd2);
    chk("t5_pos", 32'(pos), 32'd3);
    chk("t5_dir_valid", 32'(dir_valid), 32'd0);
    hold(4'b0100, 2);

    // Random walk with occasional jumps and illegal patterns
    rp = 3;
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin rp = (rp + 1) % 5; v = pats[rp]; end
      else if (r < 80) begin rp = (rp + 4) % 5; v = pats[rp]; end
      else if (r < 90) begin rp = $urandom_range(0, 4); v = pats[rp]; end
      else begin
        v = 4'($urandom_range(0, 15));
        if (decode(v) >= 0) v = 4'b0110;
      end
      n = $urandom_range(1, 4);
      hold(v, n);
    end

    // 6: 300 skips saturate the counter, then asynchronous reset mid-stream
    hold(4'b0000, 4);
    for (int k = 0; k < 150; k++) begin
      tick(4'b0010);
      tick(4'b0000);
    end
    hold(4'b0010, 2);
    chk("t6_sat", 32'(err_cnt), 32'd255);
    chk("t6_sat_pulse", 32'(err_pulse), 32'd1);
    tick(4'b0000);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_all();
    chk("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("t6_rst_locked", 32'(locked), 32'd0);
    led = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    hold(4'b0000, 3);
    chk("t6_relock", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
